// File: rtl/row_check.sv
// Row occupancy scanner: walks one board row through a 1-cycle-latency RAM and reports full/not-full.
// Optional ROW_CHECK_SCAN_ALL_EN: scan every cell and report filled_count instead of exiting early.
module row_check #(
    parameter int BOARD_W  = 10,
    parameter int BOARD_H  = 20,
    parameter int ID_W     = 3,
    parameter int EMPTY_ID = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_check,
    input  logic [4:0]      row,
    input  logic [ID_W-1:0] read_id,
    output logic [4:0]      read_x,
    output logic [4:0]      read_y,
    output logic            busy,
    output logic            fail_or_full,
`ifdef ROW_CHECK_SCAN_ALL_EN
    output logic [4:0]      filled_count,
`endif
    output logic            full
);

    // state | meaning
    // IDLE  | waiting for start_check; result flags held
    // SCAN  | issuing column reads and comparing returned ids
    typedef enum logic [0:0] {IDLE, SCAN} state_t;

    localparam logic [4:0]      LAST_X  = 5'(BOARD_W - 1);
    localparam logic [4:0]      ROW_LIM = 5'(BOARD_H);
    localparam logic [ID_W-1:0] EMPTY   = ID_W'(EMPTY_ID);

    state_t     state, state_nxt;
    logic [4:0] read_x_nxt, read_y_nxt;
    logic       busy_nxt, fail_or_full_nxt, full_nxt;
    logic       pend, pend_nxt;
    logic [4:0] pend_x, pend_x_nxt;
    logic       cell_ok;
`ifdef ROW_CHECK_SCAN_ALL_EN
    localparam logic [4:0] FULL_CNT = 5'(BOARD_W);
    logic [4:0] filled_count_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            read_x       <= '0;
            read_y       <= '0;
            busy         <= 1'b0;
            fail_or_full <= 1'b0;
            full         <= 1'b0;
            pend         <= 1'b0;
            pend_x       <= '0;
`ifdef ROW_CHECK_SCAN_ALL_EN
            filled_count <= '0;
`endif
        end else begin
            state        <= state_nxt;
            read_x       <= read_x_nxt;
            read_y       <= read_y_nxt;
            busy         <= busy_nxt;
            fail_or_full <= fail_or_full_nxt;
            full         <= full_nxt;
            pend         <= pend_nxt;
            pend_x       <= pend_x_nxt;
`ifdef ROW_CHECK_SCAN_ALL_EN
            filled_count <= filled_count_nxt;
`endif
        end
    end

    assign cell_ok = (read_id != EMPTY);

    always_comb begin
        state_nxt        = state;
        read_x_nxt       = read_x;
        read_y_nxt       = read_y;
        busy_nxt         = busy;
        fail_or_full_nxt = fail_or_full;
        full_nxt         = full;
        pend_nxt         = 1'b0;
        pend_x_nxt       = pend_x;
`ifdef ROW_CHECK_SCAN_ALL_EN
        filled_count_nxt = filled_count;
`endif
        case (state)
            IDLE: begin
                if (start_check) begin
                    fail_or_full_nxt = 1'b0;
                    full_nxt         = 1'b0;
                    read_x_nxt       = '0;
`ifdef ROW_CHECK_SCAN_ALL_EN
                    filled_count_nxt = '0;
`endif
                    if (row >= ROW_LIM) begin
                        // out-of-range row fails immediately without touching the RAM
                        fail_or_full_nxt = 1'b1;
                    end else begin
                        read_y_nxt = row;
                        busy_nxt   = 1'b1;
                        state_nxt  = SCAN;
                    end
                end
            end
            SCAN: begin
                pend_nxt   = 1'b1;
                pend_x_nxt = read_x;
                if (read_x < LAST_X)
                    read_x_nxt = read_x + 5'd1;
                if (pend) begin
`ifdef ROW_CHECK_SCAN_ALL_EN
                    if (cell_ok)
                        filled_count_nxt = filled_count + 5'd1;
                    if (pend_x == LAST_X) begin
                        fail_or_full_nxt = 1'b1;
                        full_nxt         = (filled_count_nxt == FULL_CNT);
                        busy_nxt         = 1'b0;
                        read_x_nxt       = '0;
                        pend_nxt         = 1'b0;
                        state_nxt        = IDLE;
                    end
`else
                    if (!cell_ok || pend_x == LAST_X) begin
                        fail_or_full_nxt = 1'b1;
                        full_nxt         = cell_ok;
                        busy_nxt         = 1'b0;
                        read_x_nxt       = '0;
                        pend_nxt         = 1'b0;
                        state_nxt        = IDLE;
                    end
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_row_check.sv
// Scoreboard bench for row_check: a behavioural board RAM, expected results queued at start, checked at result.
module tb_row_check;

    localparam int W = 10;
    localparam int H = 20;

    typedef struct {
        int full;
        int lat;
        int maxx;
        int cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_check = 1'b0;
    logic [4:0] row_in = '0;
    logic [2:0] read_id;
    logic [4:0] read_x, read_y;
    logic       busy, fail_or_full, full;
`ifdef ROW_CHECK_SCAN_ALL_EN
    logic [4:0] filled_count;
`endif

    logic [2:0] mem [0:H-1][0:W-1];
    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail = 0;

    row_check dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_check  (start_check),
        .row          (row_in),
        .read_id      (read_id),
        .read_x       (read_x),
        .read_y       (read_y),
        .busy         (busy),
        .fail_or_full (fail_or_full),
`ifdef ROW_CHECK_SCAN_ALL_EN
        .filled_count (filled_count),
`endif
        .full         (full)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        read_id <= (read_y < 5'(H) && read_x < 5'(W)) ? mem[read_y][read_x] : 3'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int r);
        exp_t e;
        int   k;
        e = '{full: 0, lat: 0, maxx: 0, cnt: 0};
        if (r >= H) return e;
        k = -1;
        for (int x = 0; x < W; x++) begin
            if (mem[r][x] != 3'd0) e.cnt++;
            else if (k < 0) k = x;
        end
`ifdef ROW_CHECK_SCAN_ALL_EN
        e.lat  = W + 1;
        e.maxx = W - 1;
        e.full = (e.cnt == W) ? 1 : 0;
`else
        if (k < 0) begin
            e.lat  = W + 1;
            e.maxx = W - 1;
            e.full = 1;
        end else begin
            e.lat  = k + 2;
            e.maxx = (k + 1 < W - 1) ? k + 1 : W - 1;
            e.full = 0;
        end
`endif
        return e;
    endfunction

    // acc: start already accepted by a held start_check; hold: leave start_check high afterwards
    task automatic scan(input int r, input bit restart, input bit hold, input bit acc);
        exp_t e;
        int   lat, maxx, busy_cnt;
        bit   yok;
        sb.push_back(model(r));
        if (!acc) begin
            start_check = 1'b1;
            row_in      = 5'(r);
        end
        @(negedge clk);
        start_check = hold;
        if (r < H) check("accept_clears_result", {31'd0, fail_or_full}, 0);
        lat = 0; maxx = 0; busy_cnt = 0; yok = 1'b1;
        while (!fail_or_full && lat < 40) begin
            if (busy) busy_cnt++;
            if (int'(read_x) > maxx) maxx = int'(read_x);
            if (busy && read_y != 5'(r)) yok = 1'b0;
            if (restart && lat == 3) begin
                start_check = 1'b1;
                row_in      = 5'd7;
            end
            if (restart && lat == 4) start_check = 1'b0;
            @(negedge clk);
            lat++;
        end
        check("timeout", {31'd0, (lat >= 40)}, 0);
        e = sb.pop_front();
        check("latency", lat, e.lat);
        check("full", {31'd0, full}, e.full);
        check("busy_cycles", busy_cnt, e.lat);
        check("busy_low_at_result", {31'd0, busy}, 0);
        check("max_read_x", maxx, e.maxx);
        check("read_y_stable", {31'd0, yok}, 1);
`ifdef ROW_CHECK_SCAN_ALL_EN
        check("filled_count", filled_count, e.cnt);
`endif
        if (!hold) begin
            @(negedge clk);
            @(negedge clk);
            check("result_held", {30'd0, fail_or_full, full}, {30'd0, 1'b1, 1'(e.full)});
        end
    endtask

    initial begin
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                mem[y][x] = 3'($urandom_range(1, 7));
        mem[19][0] = 3'd0;
        mem[0][9]  = 3'd0;
        mem[8][4]  = 3'd0;
        mem[8][7]  = 3'd0;
        mem[2][6]  = 3'd0;

        repeat (3) @(negedge clk);
        check("rst_outputs", {21'd0, read_x, read_y, busy, fail_or_full, full}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        scan(5, 0, 0, 0);
        scan(19, 0, 0, 0);
        scan(0, 0, 0, 0);
        scan(8, 0, 0, 0);
        scan(20, 0, 0, 0);
        check("oor_read_x", read_x, 0);
        scan(3, 1, 0, 0);

        // back-to-back: start held through the result of the first scan
        scan(2, 0, 1, 0);
        scan(2, 0, 0, 1);

        // reset in the middle of a scan
        start_check = 1'b1;
        row_in      = 5'd3;
        @(negedge clk);
        start_check = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("busy_before_reset", {31'd0, busy}, 1);
        rst_n = 1'b0;
        #1;
        check("mid_scan_reset", {21'd0, read_x, read_y, busy, fail_or_full, full}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {31'd0, busy}, 0);
        scan(7, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/row_check.md
Name: row_check

Overview:
- Board-scan responder paired with the row-clear sequencer.
- The sequencer raises start_check with a row index. This block walks that row of the board memory cell by cell and reports whether every cell is occupied.
- It returns the level-held result pair fail_or_full/full that the sequencer consumes.
- It drives the board read port (read_x, read_y) and consumes read_id, which the synchronous RAM returns one cycle after the address.

Parameters:
- BOARD_W, 10, cells per row; x counter width 5.
- BOARD_H, 20, rows on board; valid rows 0..BOARD_H-1.
- ID_W, 3, width of a cell id.
- EMPTY_ID, 0, id value meaning an unoccupied cell.

Ports:
- clk  input  1  system clock, all state on rising edge.
- Reset  input  1  asynchronous, active-low reset; low forces the IDLE state and output reset values immediately.
- start_check  input  1  request to scan row; sampled only in IDLE.
- row  input  5  row index to scan; latched when start_check is accepted.
- read_id  input  ID_W  board RAM read data, valid one cycle after read_x/read_y.
- read_x  output  5  board RAM column address.
- read_y  output  5  board RAM row address; equals the latched row.
- busy  output  1  high while a scan is in progress.
- fail_or_full  output  1  result valid; held until next accepted start_check or reset.
- full  output  1  row fully occupied; meaningful only when fail_or_full=1; held with it.

Behaviour:
- Reset values: state IDLE, read_x=0, read_y=0, busy=0, fail_or_full=0, full=0, internal pending-compare flag=0.
- IDLE:
  - start_check=1 at an edge: latch row into read_y, clear fail_or_full and full, set read_x=0, busy=1, go to SCAN.
  - If row >= BOARD_H, go instead to IDLE at the same edge with fail_or_full=1, full=0, busy=0. No RAM read is issued.
- SCAN:
  - Each edge advances read_x by 1 while read_x < BOARD_W-1. At BOARD_W-1, read_x holds.
  - A 1-cycle-delayed copy of the issued column plus a valid flag marks when read_id belongs to the previous address.
  - On each edge with the valid flag set, compare read_id against EMPTY_ID.
  - Compared cell == EMPTY_ID: early exit. fail_or_full=1, full=0, busy=0, read_x=0, go to IDLE.
  - Compared cell is column BOARD_W-1 and nonzero: fail_or_full=1, full=1, busy=0, read_x=0, go to IDLE.
- Latency, counted in edges after the accepting edge:
  - Full row: result after BOARD_W+1 edges (11 at default).
  - First empty cell at column k: result after k+2 edges.
  - Out-of-range row: result at the accepting edge itself.
- start_check while busy: ignored; the scan continues unaffected.
- start_check held high: the next scan is accepted on the first IDLE edge after the result, i.e. back-to-back scans are allowed. The result flags are cleared on that acceptance.
- No combinational path from inputs to outputs; all outputs are registered.
- Reset low mid-scan: immediate return to reset values; the partial scan is discarded.
- The RAM write side is owned by the sequencer. This block never writes.

Optional Feature:
- Macro ROW_CHECK_SCAN_ALL_EN.
- Defined:
  - Adds output filled_count (5 bits, reset 0) holding the number of non-EMPTY_ID cells in the scanned row. It is valid with fail_or_full and cleared on acceptance.
  - Early exit is disabled. Every in-range scan reads all BOARD_W cells, with fixed latency BOARD_W+1 edges.
  - full=1 iff filled_count==BOARD_W.
- Undefined: port absent, early-exit behaviour as above.

Test Plan:
- Row 5 all ids nonzero, pulse start_check -> busy=1 for 11 cycles, read_x sweeps 0..9 with read_y=5, then fail_or_full=1, full=1, busy=0. Both flags held until the next start.
- Row 19 with cell x=0 empty -> fail_or_full=1, full=0 after 2 edges; read_x never exceeds 1.
- Row 0 with only x=9 empty -> fail_or_full=1, full=0 after 11 edges.
  - With ROW_CHECK_SCAN_ALL_EN: filled_count=9.
- row=20 -> fail_or_full=1, full=0 at the accepting edge; busy never rises; read_x stays 0.
- Start row 3, assert start_check again with row 7 at edge 4 -> ignored, read_y stays 3, result for row 3. Then Reset low at edge 3 of a new scan -> all outputs 0 immediately, state IDLE, next start accepted normally.
